// File: rtl/lm_sm_sequencer.sv
// LM/SM micro-sequencer: expands one load/store-multiple into one memory beat per mask bit,
// stalling upstream until the last beat issues.
module lm_sm_sequencer #(
  parameter int unsigned WIDTH = 16,
  parameter logic [3:0]  LM_OP = 4'b0110,
  parameter logic [3:0]  SM_OP = 4'b0111
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [15:0]      IR_in,
  input  logic [WIDTH-1:0] base_addr,
  input  logic             flush,
  output logic             stall_out,
  output logic             busy,
  output logic             beat_valid,
  output logic [WIDTH-1:0] mem_addr,
  output logic             mem_write,
  output logic [2:0]       reg_idx,
  output logic             rf_wr_en,
  output logic             done
);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e           state_q, state_d;
  logic [7:0]       rem_mask_q, rem_mask_d;
  logic [WIDTH-1:0] addr_q, addr_d;
  logic             is_sm_q, is_sm_d;

  logic       is_lmsm;
  logic       accept;
  logic [2:0] low_idx;
  logic       last_beat;

  assign is_lmsm   = (IR_in[15:12] == LM_OP) || (IR_in[15:12] == SM_OP);
  assign accept    = in_valid & is_lmsm & (|IR_in[7:0]) & ~flush;
  // Only one bit left means this is the final beat.
  assign last_beat = ((rem_mask_q & (rem_mask_q - 8'd1)) == 8'd0);

  // Descending scan so the lowest set bit is the last one written.
  always_comb begin
    low_idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (rem_mask_q[i]) low_idx = 3'(i);
    end
  end

  always_comb begin
    state_d    = state_q;
    rem_mask_d = rem_mask_q;
    addr_d     = addr_q;
    is_sm_d    = is_sm_q;
    stall_out  = 1'b0;
    busy       = 1'b0;
    beat_valid = 1'b0;
    mem_addr   = '0;
    mem_write  = 1'b0;
    reg_idx    = 3'd0;
    rf_wr_en   = 1'b0;
    done       = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          stall_out  = 1'b1;
          state_d    = StRun;
          rem_mask_d = IR_in[7:0];
          addr_d     = base_addr;
          is_sm_d    = (IR_in[15:12] == SM_OP);
        end
      end
      StRun: begin
        busy       = 1'b1;
        beat_valid = 1'b1;
        mem_addr   = addr_q;
        reg_idx    = low_idx;
        mem_write  = is_sm_q & ~flush;
        rf_wr_en   = ~is_sm_q & ~flush;
        rem_mask_d = rem_mask_q & ~(8'd1 << low_idx);
        addr_d     = addr_q + 1'b1;
        if (flush) begin
          state_d    = StIdle;
          rem_mask_d = 8'd0;
        end else if (last_beat) begin
          done    = 1'b1;
          state_d = StIdle;
        end else begin
          stall_out = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    // Quiet outputs while reset is asserted.
    if (reset) begin
      stall_out  = 1'b0;
      busy       = 1'b0;
      beat_valid = 1'b0;
      mem_addr   = '0;
      mem_write  = 1'b0;
      reg_idx    = 3'd0;
      rf_wr_en   = 1'b0;
      done       = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      rem_mask_q <= 8'd0;
      addr_q     <= '0;
      is_sm_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      rem_mask_q <= rem_mask_d;
      addr_q     <= addr_d;
      is_sm_q    <= is_sm_d;
    end
  end

endmodule

// File: tb/tb_lm_sm_sequencer.sv
// Bench for lm_sm_sequencer: directed vector table, hand-written corner sequences, then
// randomized traffic against a beat-queue reference model.
module tb_lm_sm_sequencer;

  typedef struct packed {
    logic        stall;
    logic        busy;
    logic        bv;
    logic [15:0] addr;
    logic        mw;
    logic [2:0]  ridx;
    logic        rfw;
    logic        done;
  } outs_t;

  typedef struct {
    logic        rst;
    logic        iv;
    logic [15:0] ir;
    logic [15:0] base;
    logic        fl;
    outs_t       exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset, in_valid, flush;
  logic [15:0] IR_in, base_addr;
  logic        stall_out, busy, beat_valid, mem_write, rf_wr_en, done;
  logic [15:0] mem_addr;
  logic [2:0]  reg_idx;

  int errors = 0;
  int checks = 0;
  vec_t vecs[$];

  // Reference model: pending beats as a queue of {addr, reg}.
  logic [15:0] q_addr[$];
  logic [2:0]  q_reg[$];
  logic        m_sm;

  lm_sm_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .IR_in      (IR_in),
    .base_addr  (base_addr),
    .flush      (flush),
    .stall_out  (stall_out),
    .busy       (busy),
    .beat_valid (beat_valid),
    .mem_addr   (mem_addr),
    .mem_write  (mem_write),
    .reg_idx    (reg_idx),
    .rf_wr_en   (rf_wr_en),
    .done       (done)
  );

  always #5 clk = ~clk;

  function automatic outs_t mk(input logic st, input logic bz, input logic bv,
                               input logic [15:0] a, input logic mw, input logic [2:0] r,
                               input logic rfw, input logic dn);
    outs_t o;
    o.stall = st; o.busy = bz; o.bv = bv; o.addr = a;
    o.mw = mw; o.ridx = r; o.rfw = rfw; o.done = dn;
    return o;
  endfunction

  function automatic outs_t actual();
    return mk(stall_out, busy, beat_valid, mem_addr, mem_write, reg_idx, rf_wr_en, done);
  endfunction

  task automatic check(input string name, input outs_t exp);
    outs_t act;
    act = actual();
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got stall=%b busy=%b bv=%b addr=%h mw=%b reg=%0d rfw=%b done=%b ; want stall=%b busy=%b bv=%b addr=%h mw=%b reg=%0d rfw=%b done=%b",
               name, act.stall, act.busy, act.bv, act.addr, act.mw, act.ridx, act.rfw, act.done,
               exp.stall, exp.busy, exp.bv, exp.addr, exp.mw, exp.ridx, exp.rfw, exp.done);
    end
  endtask

  // Drive at negedge, sample 1ns later, well away from the rising edge.
  task automatic drive(input logic rst, input logic iv, input logic [15:0] ir,
                       input logic [15:0] base, input logic fl);
    @(negedge clk);
    reset = rst; in_valid = iv; IR_in = ir; base_addr = base; flush = fl;
    #1;
  endtask

  task automatic add(input logic rst, input logic iv, input logic [15:0] ir,
                     input logic [15:0] base, input logic fl, input outs_t exp);
    vec_t v;
    v.rst = rst; v.iv = iv; v.ir = ir; v.base = base; v.fl = fl; v.exp = exp;
    vecs.push_back(v);
  endtask

  function automatic logic model_accept();
    return in_valid && (IR_in[15:12] == 4'b0110 || IR_in[15:12] == 4'b0111) &&
           IR_in[7:0] != 8'd0 && !flush;
  endfunction

  function automatic outs_t model_out();
    if (reset) return '0;
    if (q_addr.size() > 0)
      return mk(q_addr.size() > 1 && !flush, 1'b1, 1'b1, q_addr[0], m_sm && !flush, q_reg[0],
                !m_sm && !flush, q_addr.size() == 1 && !flush);
    return mk(model_accept(), 1'b0, 1'b0, 16'h0, 1'b0, 3'd0, 1'b0, 1'b0);
  endfunction

  task automatic model_step();
    int n;
    if (reset) begin
      q_addr.delete(); q_reg.delete();
    end else if (q_addr.size() > 0) begin
      if (flush) begin
        q_addr.delete(); q_reg.delete();
      end else begin
        void'(q_addr.pop_front()); void'(q_reg.pop_front());
      end
    end else if (model_accept()) begin
      n = 0;
      m_sm = (IR_in[15:12] == 4'b0111);
      for (int b = 0; b < 8; b++) begin
        if (IR_in[b]) begin
          q_addr.push_back(16'(base_addr + n));
          q_reg.push_back(3'(b));
          n++;
        end
      end
    end
  endtask

  localparam outs_t Z = '0;

  initial begin
    reset = 1'b1; in_valid = 1'b0; IR_in = 16'h0; base_addr = 16'h0; flush = 1'b0;
    m_sm = 1'b0;
    repeat (2) @(posedge clk);

    // T1: LM mask 0x05 base 0x0010
    add(1, 1, 16'h6005, 16'h0010, 0, Z);
    add(0, 1, 16'h6005, 16'h0010, 0, mk(1, 0, 0, 16'h0000, 0, 0, 0, 0));
    add(0, 1, 16'h6005, 16'h0010, 0, mk(1, 1, 1, 16'h0010, 0, 0, 1, 0));
    add(0, 0, 16'h0000, 16'h0000, 0, mk(0, 1, 1, 16'h0011, 0, 2, 1, 1));
    add(0, 0, 16'h0000, 16'h0000, 0, Z);
    // T3: LM mask 0, ADD, and flush blocking an accept in IDLE
    add(0, 1, 16'h6000, 16'h1234, 0, Z);
    add(0, 1, 16'h0000, 16'h1234, 0, Z);
    add(0, 1, 16'h6003, 16'h1234, 1, Z);
    add(0, 0, 16'h0000, 16'h0000, 0, Z);
    // T6: back-to-back LM 0x01 then SM 0x02
    add(0, 1, 16'h6001, 16'h0100, 0, mk(1, 0, 0, 16'h0000, 0, 0, 0, 0));
    add(0, 1, 16'h7002, 16'h0200, 0, mk(0, 1, 1, 16'h0100, 0, 0, 1, 1));
    add(0, 1, 16'h7002, 16'h0200, 0, mk(1, 0, 0, 16'h0000, 0, 0, 0, 0));
    add(0, 0, 16'h0000, 16'h0000, 0, mk(0, 1, 1, 16'h0200, 1, 1, 0, 1));
    add(0, 0, 16'h0000, 16'h0000, 0, Z);
    // T4: SM mask 0x0F, flush on second beat
    add(0, 1, 16'h700F, 16'h0040, 0, mk(1, 0, 0, 16'h0000, 0, 0, 0, 0));
    add(0, 1, 16'h700F, 16'h0040, 0, mk(1, 1, 1, 16'h0040, 1, 0, 0, 0));
    add(0, 1, 16'h700F, 16'h0040, 1, mk(0, 1, 1, 16'h0041, 0, 1, 0, 0));
    add(0, 0, 16'h0000, 16'h0000, 0, Z);
    add(0, 0, 16'h0000, 16'h0000, 0, Z);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].iv, vecs[i].ir, vecs[i].base, vecs[i].fl);
      check($sformatf("vec%0d", i), vecs[i].exp);
    end

    // T2: SM 0xFF from 0xFFFE wraps the address
    begin
      int stalls = 0;
      drive(0, 1, 16'h70FF, 16'hFFFE, 0);
      stalls += stall_out;
      check("t2_accept", mk(1, 0, 0, 16'h0, 0, 0, 0, 0));
      for (int i = 0; i < 8; i++) begin
        drive(0, 0, 16'h0, 16'h0, 0);
        stalls += stall_out;
        check($sformatf("t2_beat%0d", i),
              mk(i != 7, 1, 1, 16'(16'hFFFE + i), 1, 3'(i), 0, i == 7));
      end
      drive(0, 0, 16'h0, 16'h0, 0);
      check("t2_after", Z);
      checks++;
      if (stalls != 8) begin
        errors++;
        $display("FAIL t2_stall_cycles: got %0d want 8", stalls);
      end
    end

    // T5: reset on the 3rd beat of LM 0xE0, then SM 0x80
    drive(0, 1, 16'h60E0, 16'h0300, 0);
    check("t5_accept", mk(1, 0, 0, 16'h0, 0, 0, 0, 0));
    drive(0, 0, 16'h0, 16'h0, 0);
    check("t5_beat0", mk(1, 1, 1, 16'h0300, 0, 5, 1, 0));
    drive(0, 0, 16'h0, 16'h0, 0);
    check("t5_beat1", mk(1, 1, 1, 16'h0301, 0, 6, 1, 0));
    drive(1, 0, 16'h0, 16'h0, 0);
    check("t5_reset", Z);
    drive(0, 0, 16'h0, 16'h0, 0);
    check("t5_idle", Z);
    drive(0, 1, 16'h7080, 16'h0500, 0);
    check("t5_sm_accept", mk(1, 0, 0, 16'h0, 0, 0, 0, 0));
    drive(0, 0, 16'h0, 16'h0, 0);
    check("t5_sm_beat", mk(0, 1, 1, 16'h0500, 1, 7, 0, 1));
    drive(0, 0, 16'h0, 16'h0, 0);
    check("t5_sm_after", Z);

    // Random traffic against the model, starting from a reset
    drive(1, 0, 16'h0, 16'h0, 0);
    model_step();
    for (int c = 0; c < 3000; c++) begin
      logic [3:0]  op;
      logic [7:0]  mask;
      int          sel;
      sel  = $urandom_range(0, 9);
      op   = (sel < 4) ? 4'b0110 : (sel < 8) ? 4'b0111 : 4'($urandom_range(0, 15));
      mask = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      drive($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0,
            {op, 4'($urandom), mask}, 16'($urandom), $urandom_range(0, 11) == 0);
      check($sformatf("rand%0d", c), model_out());
      model_step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
